// File: rtl/synth_pkg.sv
// ---------------------------------------------------------------------------
// synth_pkg: widths, CIC constants and saturation shared by the PCM blocks. rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package synth_pkg;

  localparam int NBITS     = 10;
  localparam int CIC_R     = 32;
  localparam int CIC_W     = 11;
  localparam int CIC_RBITS = $clog2(CIC_R);

  localparam logic [NBITS-1:0] SAT_MAX = 10'd1023;

  typedef logic [CIC_W-1:0] cic_word_t;

  typedef enum logic [1:0] {
    WARM_SKIP0 = 2'd0,
    WARM_SKIP1 = 2'd1,
    WARM_RUN   = 2'd2
  } warm_state_t;

  // Full-scale input lands exactly on 1024, one past the PCM range.
  function automatic logic [NBITS-1:0] saturate(input cic_word_t v);
    return (v > CIC_W'(SAT_MAX)) ? SAT_MAX : v[NBITS-1:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/cic2_decim.sv
// ---------------------------------------------------------------------------
// cic2_decim: 2nd-order CIC decimator (R=32, M=1) on a 1-bit input stream. rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module cic2_decim
  import synth_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      clr,
  input  logic      bit_in,
  input  logic      strobe,
  output cic_word_t result,
  output logic      valid
);

  cic_word_t            i1;
  cic_word_t            i2;
  cic_word_t            d1;
  cic_word_t            d2;
  cic_word_t            c1;
  logic [CIC_RBITS-1:0] bit_cnt;
  logic                 dec_strobe;
  logic                 dec_pend;

  assign dec_strobe = strobe && (bit_cnt == CIC_RBITS'(CIC_R - 1));

  // Modular wrap of the integrators cancels in the comb differences.
  assign c1     = i2 - d1;
  assign result = c1 - d2;
  assign valid  = dec_pend;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i1       <= '0;
      i2       <= '0;
      d1       <= '0;
      d2       <= '0;
      bit_cnt  <= '0;
      dec_pend <= 1'b0;
    end else if (clr) begin
      i1       <= '0;
      i2       <= '0;
      d1       <= '0;
      d2       <= '0;
      bit_cnt  <= '0;
      dec_pend <= 1'b0;
    end else begin
      dec_pend <= dec_strobe;
      if (strobe) begin
        i1      <= i1 + CIC_W'(bit_in);
        i2      <= i2 + i1;
        bit_cnt <= bit_cnt + CIC_RBITS'(1);
      end
      if (dec_pend) begin
        d1 <= i2;
        d2 <= c1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/pdm_demod.sv
// ---------------------------------------------------------------------------
// pdm_demod: PDM microphone clock generator and CIC decoder to 10-bit PCM. rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pdm_demod
  import synth_pkg::*;
#(
  parameter int CLK_HALF_DIV = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic             pdm_clk,
  input  logic             pdm_data,
  output logic [NBITS-1:0] sample,
  output logic             sample_valid
);

  localparam int               DIV_W    = (CLK_HALF_DIV > 1) ? $clog2(CLK_HALF_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_HALF_DIV - 1);

  logic [DIV_W-1:0] div_cnt;
  logic [1:0]       sync_ff;
  logic             div_wrap;
  logic             bit_strobe;
  logic             cic_clr;
  cic_word_t        cic_result;
  logic             cic_valid;
  warm_state_t      warm_state;

  assign div_wrap   = (div_cnt == DIV_LAST);
  // The captured bit is whatever the synchronizer holds as pdm_clk is driven high.
  assign bit_strobe = en && div_wrap && !pdm_clk;
  assign cic_clr    = !en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      pdm_clk <= 1'b0;
    end else if (!en) begin
      div_cnt <= '0;
      pdm_clk <= 1'b0;
    end else if (div_wrap) begin
      div_cnt <= '0;
      pdm_clk <= !pdm_clk;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_ff <= '0;
    end else begin
      sync_ff <= {sync_ff[0], pdm_data};
    end
  end

  cic2_decim u_cic (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (cic_clr),
    .bit_in (sync_ff[1]),
    .strobe (bit_strobe),
    .result (cic_result),
    .valid  (cic_valid)
  );

  // The first two outputs come from a partly filled comb history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      warm_state   <= WARM_SKIP0;
      sample       <= '0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      if (!en) begin
        warm_state <= WARM_SKIP0;
      end else if (cic_valid) begin
        case (warm_state)
          WARM_SKIP0: warm_state <= WARM_SKIP1;
          WARM_SKIP1: warm_state <= WARM_RUN;
          WARM_RUN: begin
            sample       <= saturate(cic_result);
            sample_valid <= 1'b1;
          end
          default:    warm_state <= WARM_SKIP0;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pdm_demod.sv
// ---------------------------------------------------------------------------
// tb_pdm_demod: self-checking bench for pdm_demod using a direct-form FIR model. rev 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_pdm_demod;

  localparam int HALF = 20;
  localparam int WIN  = 32 * 2 * HALF;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic       en       = 1'b0;
  logic       pdm_data = 1'b0;
  logic       pdm_clk;
  logic [9:0] sample;
  logic       sample_valid;

  pdm_demod #(.CLK_HALF_DIV(HALF)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .pdm_clk      (pdm_clk),
    .pdm_data     (pdm_data),
    .sample       (sample),
    .sample_valid (sample_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    int value;
    int due;
  } exp_t;

  typedef struct {
    string name;
    int    mode;     // 0 const0, 1 const1, 2 alternating, 3 sigma-delta
    int    din;
    int    nominal;
    int    tol;
  } vec_t;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   mode = 0;
  int   din = 0;
  int   nominal = 0;
  int   tol = 0;
  int   rise_cnt = 0;
  int   gen_idx = 0;
  int   sd_acc = 0;
  int   pulses = 0;
  int   last_exp = 0;
  logic prev_pdm_clk = 1'b0;
  bit   hist[$];
  exp_t sb[$];

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d..%0d (t=%0t)", name, act, lo, hi, $time);
    end
  endtask

  // Stimulus source: one bit per pdm_clk period, changed on the falling edge.
  task automatic next_bit();
    logic b;
    case (mode)
      0: b = 1'b0;
      1: b = 1'b1;
      2: b = (gen_idx % 2 == 0);
      default: begin
        sd_acc += din;
        if (sd_acc >= 1024) begin
          sd_acc -= 1024;
          b = 1'b1;
        end else begin
          b = 1'b0;
        end
      end
    endcase
    gen_idx++;
    pdm_data = b;
  endtask

  // Triangular FIR equivalent of the CIC; the bit captured at the decimation
  // strobe itself has weight zero.
  function automatic int model_out();
    int y = 0;
    int n = hist.size();
    for (int a = 1; a < 64; a++) begin
      if (n - 1 - a >= 0 && hist[n - 1 - a]) y += (a <= 32) ? a : 64 - a;
    end
    return (y >= 1024) ? 1023 : y;
  endfunction

  task automatic model_clear();
    rise_cnt = 0;
    hist.delete();
    sb.delete();
    gen_idx = 0;
    sd_acc  = 0;
    next_bit();
  endtask

  initial begin : monitor
    exp_t e;
    logic exp_v;
    forever begin
      @(negedge clk);
      cyc++;
      if (pdm_clk && !prev_pdm_clk) begin
        hist.push_back(pdm_data);
        if (hist.size() > 64) void'(hist.pop_front());
        rise_cnt++;
        if (rise_cnt % 32 == 0 && rise_cnt / 32 >= 3) begin
          e.value = model_out();
          e.due   = cyc + 1;
          sb.push_back(e);
        end
      end
      if (!pdm_clk && prev_pdm_clk) next_bit();
      prev_pdm_clk = pdm_clk;

      exp_v = (sb.size() > 0 && sb[0].due <= cyc);
      if (sample_valid || exp_v) begin
        check("sample_valid", int'(sample_valid), int'(exp_v));
        if (exp_v) begin
          e = sb.pop_front();
          last_exp = e.value;
          if (sample_valid) begin
            pulses++;
            check("sample_model", int'(sample), e.value);
            check_range("sample_nominal", int'(sample), nominal - tol, nominal + tol);
          end
        end
      end
    end
  end

  task automatic at_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    at_edge();
    rst_n = 1'b0;
    sb.delete();
    repeat (3) at_edge();
    model_clear();
    rst_n = 1'b1;
  endtask

  task automatic wait_outputs(input int n);
    int bound;
    int done;
    bound = n * WIN + 200;
    done  = 0;
    for (int k = 0; k < bound; k++) begin
      at_edge();
      if (rise_cnt >= 32 * n && sb.size() == 0) begin
        done = 1;
        break;
      end
    end
    check("outputs_reached", done, 1);
  endtask

  task automatic wait_rises(input int n);
    for (int k = 0; k < n * 2 * HALF + 100; k++) begin
      at_edge();
      if (rise_cnt >= n) break;
    end
  endtask

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    vec_t vecs[5];
    int   cnt;
    int   p0;
    int   held;

    vecs[0] = '{"const_one",  1, 0,   1023, 0};
    vecs[1] = '{"const_zero", 0, 0,   0,    0};
    vecs[2] = '{"alternate",  2, 0,   512,  0};
    vecs[3] = '{"sd_256",     3, 256, 256,  2};
    vecs[4] = '{"sd_768",     3, 768, 768,  2};

    // Reset values and pdm_clk timing
    mode = 1; nominal = 1023; tol = 0;
    en = 1'b1;
    repeat (2) at_edge();
    check("rst_pdm_clk", int'(pdm_clk), 0);
    check("rst_sample", int'(sample), 0);
    check("rst_sample_valid", int'(sample_valid), 0);
    model_clear();
    rst_n = 1'b1;
    cnt = 0;
    for (int k = 0; k < 100; k++) begin
      at_edge();
      cnt++;
      if (pdm_clk) break;
    end
    check("first_rise_cycles", cnt, HALF);
    cnt = 0;
    for (int k = 0; k < 100; k++) begin
      at_edge();
      cnt++;
      if (!pdm_clk) break;
    end
    check("pdm_clk_high_cycles", cnt, HALF);
    cnt = 0;
    for (int k = 0; k < 100; k++) begin
      at_edge();
      cnt++;
      if (pdm_clk) break;
    end
    check("pdm_clk_low_cycles", cnt, HALF);

    // Steady-state patterns
    foreach (vecs[i]) begin
      mode = vecs[i].mode; din = vecs[i].din;
      nominal = vecs[i].nominal; tol = vecs[i].tol;
      do_reset();
      p0 = pulses;
      wait_outputs(4);
      check({vecs[i].name, "_pulses"}, pulses - p0, 2);
      repeat (50) at_edge();
      check({vecs[i].name, "_hold"}, int'(sample), last_exp);
    end

    // Asynchronous reset in the middle of a window
    mode = 1; nominal = 1023; tol = 0;
    do_reset();
    wait_outputs(3);
    wait_rises(32 * 3 + 10);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("async_rst_pdm_clk", int'(pdm_clk), 0);
    check("async_rst_sample", int'(sample), 0);
    check("async_rst_valid", int'(sample_valid), 0);
    repeat (3) at_edge();
    model_clear();
    rst_n = 1'b1;
    p0 = pulses;
    wait_outputs(3);
    check("post_rst_pulses", pulses - p0, 1);

    // Enable dropped mid-window, then restored
    mode = 2; nominal = 512; tol = 0;
    do_reset();
    wait_outputs(3);
    wait_rises(32 * 3 + 12);
    at_edge();
    en = 1'b0;
    sb.delete();
    held = last_exp;
    at_edge();
    cnt = 0;
    p0 = pulses;
    for (int k = 0; k < 99; k++) begin
      at_edge();
      if (pdm_clk) cnt++;
    end
    check("en_low_pdm_clk_high_cycles", cnt, 0);
    check("en_low_sample_held", int'(sample), held);
    model_clear();
    en = 1'b1;
    wait_outputs(2);
    check("en_warmup_pulses", pulses - p0, 0);
    wait_outputs(3);
    check("en_resume_pulses", pulses - p0, 1);

    repeat (5) at_edge();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pdm_demod.md
PDM_DEMOD -- requirements
Module: pdm_demod

Interface
REQ-001 Parameter CLK_HALF_DIV, default 20: clk cycles per pdm_clk half-period (100 MHz clk gives 2.5 MHz pdm_clk).
REQ-002 clk  input  1  single system clock; all logic on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 en  input  1  active-high enable; low means idle.
REQ-005 pdm_clk  output  1  clock driven to the external PDM microphone.
REQ-006 pdm_data  input  1  1-bit PDM stream from the microphone, asynchronous to clk.
REQ-007 sample  output  10  decoded unsigned PCM sample, 0..1023, same scale as the team's 10-bit PDM modulator input.
REQ-008 sample_valid  output  1  one-clk pulse marking a new sample.

Function
REQ-009 Divider counts 0..CLK_HALF_DIV-1 while en=1 and toggles pdm_clk on wrap, so pdm_clk has a 50% duty cycle and a period of 2*CLK_HALF_DIV clk cycles.
REQ-010 pdm_data passes through a 2-flop synchronizer before any use.
REQ-011 Bit strobe: a one-cycle internal pulse in the clk cycle in which pdm_clk is driven 0->1; the synchronizer output in that cycle is the captured bit (0 or 1).
REQ-012 Decoder is a 2nd-order CIC decimator, R=32, M=1, with a DC gain of exactly 1024.
REQ-013 Integrators are 11-bit, updated on each bit strobe: i1 <= i1 + bit; i2 <= i2 + i1 (pre-update i1).
REQ-014 Integrator overflow wraps modulo 2^11; the comb difference is correct by construction and shall not be saturated internally.
REQ-015 A 5-bit bit counter 0..31 increments on each strobe; the strobe at count 31 is the decimation strobe.
REQ-016 One clk cycle after the decimation strobe, the combs run on 11-bit values: c1 = i2 - d1, d1 <= i2; c2 = c1 - d2, d2 <= c1.
REQ-017 Output saturation: c2 >= 1024 gives sample = 1023; otherwise sample = c2[9:0].
REQ-018 sample and sample_valid are registered and become visible exactly 2 clk cycles after the decimation strobe.
REQ-019 sample holds its value between pulses.
REQ-020 Warm-up: sample_valid is suppressed for the first 2 decimated outputs after reset or after en rises; the third and later outputs pulse normally.
REQ-021 When en=0:
- pdm_clk is held at 0;
- divider, integrators, combs, bit counter and warm-up counter are cleared;
- sample_valid is 0 and sample holds its last value.
REQ-022 A decimation strobe coinciding with en falling produces no output pulse.
REQ-023 Output rate is one sample per 32*2*CLK_HALF_DIV clk cycles (1280 at default).

Reset
REQ-024 While rst_n=0:
- pdm_clk=0, sample=0, sample_valid=0;
- synchronizer flops, divider, integrators, combs, bit counter and warm-up counter are all 0.
REQ-025 Reset asserts asynchronously and takes effect mid-operation without waiting for clk.
REQ-026 Release is sampled on clk; the first pdm_clk rising edge follows CLK_HALF_DIV cycles after release with en=1.

Structure
REQ-027 Shared package synth_pkg holds:
- NBITS=10, the 10-bit PCM width common with the oscillator and modulator blocks;
- CIC_R=32, CIC_W=11 and the saturation limit 1023.
REQ-028 The CIC integrator/comb datapath is a single sub-module, cic2_decim (bit and strobe in; 11-bit result and valid out).
REQ-029 pdm_clk generation, synchronizer, warm-up and saturation stay in pdm_demod.

Verification
REQ-030 pdm_clk timing: en=1, CLK_HALF_DIV=20 -> pdm_clk period 40 clk, high for 20, first rise 20 cycles after reset release.
REQ-031 Constant levels:
- pdm_data=1 constant -> no sample_valid for the first 2 outputs, then sample=1023 every 1280 cycles;
- pdm_data=0 constant -> sample=0.
REQ-032 Alternating 1,0,1,0 bits aligned to the strobes -> steady sample=512.
REQ-033 Loopback: the team's 10-bit PDM modulator with din=256, clocked by the bit strobe -> steady sample within 256 +/-2; din=768 -> within 768 +/-2.
REQ-034 rst_n pulsed low mid-window -> all outputs 0 immediately; after release, 2 outputs suppressed, then correct values.
REQ-035 en dropped for 100 cycles, then re-raised -> pdm_clk low and no pulses while en=0; sample held; warm-up repeats before pulses resume.
